// File: rtl/gpu_pkg.sv
// Shared GPU definitions: VRAM address geometry, Object Memory placement and
// the DMA sequencer state encoding.
package gpu_pkg;

    localparam int VRAM_ADDR_WIDTH = 12;

    localparam logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE = 12'h800;
    localparam int                         OBM_SIZE = 256;

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        READ,
        WRITE,
        DONE
    } dma_state_t;

endpackage

// File: rtl/vram_write_mux.sv
// Single VRAM write port arbiter: a CPU write always wins, the DMA byte is
// offered only when the CPU is not writing.
module vram_write_mux
    import gpu_pkg::*;
(
    input  logic                       cpu_write_enable,
    input  logic [7:0]                 cpu_data,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_address,
    input  logic                       dma_write_enable,
    input  logic [7:0]                 dma_data,
    input  logic [VRAM_ADDR_WIDTH-1:0] dma_address,
    output logic [7:0]                 vram_data,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic                       vram_write_enable
);

    always_comb begin
        // NOTE: every output gets a default before the priority chain, so no path leaves one unassigned and no latch is inferred.
        vram_data         = '0;
        vram_address      = '0;
        vram_write_enable = 1'b0;
        if (cpu_write_enable) begin
            vram_data         = cpu_data;
            vram_address      = cpu_address;
            vram_write_enable = 1'b1;
        end else if (dma_write_enable) begin
            vram_data         = dma_data;
            vram_address      = dma_address;
            vram_write_enable = 1'b1;
        end
    end

endmodule

// File: rtl/obm_dma.sv
// Object Memory DMA: copies LENGTH bytes from CPU RAM page {dma_page, index}
// into VRAM at DEST_BASE, sharing the VRAM write port with direct CPU writes.
module obm_dma
    import gpu_pkg::*;
#(
    parameter int                         LENGTH    = OBM_SIZE,
    parameter logic [VRAM_ADDR_WIDTH-1:0] DEST_BASE = OBM_BASE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       writable,
    input  logic [7:0]                 cpu_data,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_address,
    input  logic                       cpu_write_enable,
    input  logic                       dma_start,
    input  logic [7:0]                 dma_page,
    output logic [15:0]                src_address,
    output logic                       src_read,
    input  logic [7:0]                 src_data,
    input  logic                       src_valid,
    output logic [7:0]                 vram_data,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic                       vram_write_enable,
    output logic                       dma_busy,
    output logic                       dma_done
);

    localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

    dma_state_t                 state;
    dma_state_t                 state_next;
    logic [7:0]                 index;
    logic [7:0]                 page;
    logic [7:0]                 buffer;
    logic                       dma_offer;
    logic                       dma_advance;
    logic [VRAM_ADDR_WIDTH-1:0] dma_address;

    // The byte is offered whenever the window is open; it only counts as
    // written when the CPU is not holding the port in the same cycle.
    assign dma_offer   = (state == WRITE) && writable;
    assign dma_advance = dma_offer && !cpu_write_enable;
    assign dma_address = DEST_BASE + {{(VRAM_ADDR_WIDTH-8){1'b0}}, index};

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the byte buffer is a single register, not a memory array, so it is cleared by reset like the rest of the state.
        if (!rst) begin
            state  <= IDLE;
            index  <= '0;
            page   <= '0;
            buffer <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state <= state_next;
            case (state)
                IDLE: begin
                    if (dma_start) begin
                        page  <= dma_page;
                        index <= '0;
                    end
                end
                READ: begin
                    if (src_valid) begin
                        buffer <= src_data;
                    end
                end
                WRITE: begin
                    if (dma_advance && (index != LAST_INDEX)) begin
                        index <= index + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        src_read    = 1'b0;
        src_address = '0;
        dma_busy    = 1'b1;
        dma_done    = 1'b0;
        case (state)
            IDLE: begin
                dma_busy = 1'b0;
                if (dma_start) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (writable) begin
                    state_next = READ;
                end
            end
            READ: begin
                // Address is a pure function of registered state, so it holds for the whole handshake.
                src_read    = 1'b1;
                src_address = {page, index};
                if (src_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (dma_advance) begin
                    state_next = (index == LAST_INDEX) ? DONE : READ;
                end
            end
            DONE: begin
                dma_done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    vram_write_mux u_vram_write_mux (
        .cpu_write_enable  (cpu_write_enable),
        .cpu_data          (cpu_data),
        .cpu_address       (cpu_address),
        .dma_write_enable  (dma_offer),
        .dma_data          (buffer),
        .dma_address       (dma_address),
        .vram_data         (vram_data),
        .vram_address      (vram_address),
        .vram_write_enable (vram_write_enable)
    );

endmodule

// File: tb/tb_obm_dma.sv
// Randomized bench for obm_dma: a source RAM model answers reads, and a
// transfer-level model predicts the VRAM write stream, busy span and done pulse.
module tb_obm_dma;
    import gpu_pkg::*;

    localparam int                         LEN  = 256;
    localparam logic [VRAM_ADDR_WIDTH-1:0] BASE = 12'h800;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       writable;
    logic [7:0]                 cpu_data;
    logic [VRAM_ADDR_WIDTH-1:0] cpu_address;
    logic                       cpu_write_enable;
    logic                       dma_start;
    logic [7:0]                 dma_page;
    logic [15:0]                src_address;
    logic                       src_read;
    logic [7:0]                 src_data;
    logic                       src_valid;
    logic [7:0]                 vram_data;
    logic [VRAM_ADDR_WIDTH-1:0] vram_address;
    logic                       vram_write_enable;
    logic                       dma_busy;
    logic                       dma_done;

    always #5 clk = ~clk;

    obm_dma #(.LENGTH(LEN), .DEST_BASE(BASE)) dut (
        .clk               (clk),
        .rst               (rst),
        .writable          (writable),
        .cpu_data          (cpu_data),
        .cpu_address       (cpu_address),
        .cpu_write_enable  (cpu_write_enable),
        .dma_start         (dma_start),
        .dma_page          (dma_page),
        .src_address       (src_address),
        .src_read          (src_read),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .vram_data         (vram_data),
        .vram_address      (vram_address),
        .vram_write_enable (vram_write_enable),
        .dma_busy          (dma_busy),
        .dma_done          (dma_done)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Source RAM contents and transfer-level model state.
    logic [7:0] mem [0:65535];
    bit         model_busy = 1'b0;
    logic [7:0] exp_page   = 8'h00;
    int         exp_n      = 0;
    int         done_cnt   = 0;
    int         dma_writes = 0;
    int         cpu_seen   = 0;

    // Stimulus knobs.
    int  lat_max     = 0;
    int  lat_target  = 0;
    int  wait_cnt    = 0;
    bit  prev_real   = 1'b0;
    bit  junk        = 1'b0;
    int  wr_low_pct  = 0;
    int  cpu_pct     = 0;
    int  wr_hold     = 0;
    int  cpu_left    = 0;
    int  drop_at     = -1;
    int  drop_len    = 0;
    int  cpu_at      = -1;
    int  restart_at  = -1;
    bit  done_restart = 1'b0;
    bit  last_written = 1'b0;

    // One clock cycle: observe at the falling edge, update the model at the
    // rising edge, then drive the next cycle's inputs 1 time unit later.
    task automatic tick();
        bit done_now;
        @(negedge clk);
        check("busy", 32'(dma_busy), 32'(model_busy));
        if (!model_busy) check("idle_quiet", 32'({src_read, dma_done}), 32'(0));
        if (cpu_write_enable) begin
            check("cpu_we", 32'(vram_write_enable), 32'(1));
            check("cpu_addr", 32'(vram_address), 32'(cpu_address));
            check("cpu_data", 32'(vram_data), 32'(cpu_data));
            cpu_seen++;
        end else if (vram_write_enable) begin
            check("dma_wr_busy", 32'(model_busy), 32'(1));
            check("dma_wr_window", 32'(writable), 32'(1));
            check("dma_wr_in_range", 32'(exp_n < LEN), 32'(1));
            check("dma_addr", 32'(vram_address), 32'(BASE) + 32'(exp_n));
            check("dma_data", 32'(vram_data), 32'(mem[{exp_page, exp_n[7:0]}]));
            exp_n++;
            dma_writes++;
            if (exp_n == LEN) last_written = 1'b1;
        end
        if (src_read) check("src_addr", 32'(src_address), 32'({exp_page, exp_n[7:0]}));
        done_now = dma_done;
        if (dma_done) begin
            check("done_after_last", 32'(exp_n), 32'(LEN));
            done_cnt++;
        end

        @(posedge clk);
        if (dma_start && !model_busy) begin
            model_busy = 1'b1;
            exp_page   = dma_page;
            exp_n      = 0;
        end
        if (done_now) model_busy = 1'b0;
        #1;

        dma_start = 1'b0;
        if (restart_at >= 0 && exp_n == restart_at) begin
            dma_start  = 1'b1;
            dma_page   = 8'hEE;
            restart_at = -1;
        end
        if (done_restart && last_written) begin
            dma_start    = 1'b1;
            dma_page     = 8'h77;
            last_written = 1'b0;
        end
        if (drop_at >= 0 && exp_n == drop_at) begin
            wr_hold = drop_len;
            drop_at = -1;
        end
        if (cpu_at >= 0 && prev_real && exp_n == cpu_at) begin
            cpu_left = 3;
            cpu_at   = -1;
        end

        if (wr_hold > 0) begin
            writable = 1'b0;
            wr_hold--;
        end else begin
            writable = ($urandom_range(99, 0) >= wr_low_pct);
        end

        if (cpu_left > 0) begin
            cpu_write_enable = 1'b1;
            cpu_address      = 12'h010;
            cpu_data         = 8'hAA;
            cpu_left--;
        end else if ($urandom_range(99, 0) < cpu_pct) begin
            cpu_write_enable = 1'b1;
            cpu_address      = 12'($urandom);
            cpu_data         = 8'($urandom);
        end else begin
            cpu_write_enable = 1'b0;
        end

        prev_real = 1'b0;
        if (src_read) begin
            if (wait_cnt >= lat_target) begin
                src_valid  = 1'b1;
                src_data   = mem[src_address];
                wait_cnt   = 0;
                lat_target = $urandom_range(lat_max, 0);
                prev_real  = 1'b1;
            end else begin
                src_valid = 1'b0;
                wait_cnt++;
            end
        end else if (junk) begin
            src_valid = 1'($urandom_range(1, 0));
            src_data  = 8'($urandom);
        end else begin
            src_valid = 1'b0;
        end
    endtask

    task automatic start(input logic [7:0] page);
        dma_writes   = 0;
        done_cnt     = 0;
        cpu_seen     = 0;
        last_written = 1'b0;
        dma_start    = 1'b1;
        dma_page     = page;
        tick();
    endtask

    task automatic run_until_idle(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (model_busy && cycles < budget) begin
            tick();
            cycles++;
        end
        check({tag, "_timeout"}, 32'(model_busy), 32'(0));
    endtask

    task automatic set_mode(input int lat, input int wr_pct, input int c_pct, input bit j);
        lat_max    = lat;
        lat_target = 0;
        wait_cnt   = 0;
        wr_low_pct = wr_pct;
        cpu_pct    = c_pct;
        junk       = j;
    endtask

    task automatic check_transfer(input string tag);
        check({tag, "_writes"}, 32'(dma_writes), 32'(LEN));
        check({tag, "_done_once"}, 32'(done_cnt), 32'(1));
    endtask

    int cyc;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rst              = 1'b0;
        writable         = 1'b0;
        cpu_data         = '0;
        cpu_address      = '0;
        cpu_write_enable = 1'b0;
        dma_start        = 1'b0;
        dma_page         = '0;
        src_data         = '0;
        src_valid        = 1'b0;
        #12;
        check("rst_src_read", 32'(src_read), 32'(0));
        check("rst_src_addr", 32'(src_address), 32'(0));
        check("rst_busy", 32'(dma_busy), 32'(0));
        check("rst_done", 32'(dma_done), 32'(0));
        check("rst_vram_we", 32'(vram_write_enable), 32'(0));
        @(posedge clk);
        #1;
        rst      = 1'b1;
        writable = 1'b1;
        repeat (3) tick();

        // Full-rate transfer from page 0x02: PEND + 2 cycles/byte + DONE.
        set_mode(0, 0, 0, 1'b0);
        start(8'h02);
        run_until_idle("t1", 2000, cyc);
        check_transfer("t1");
        check("t1_cycles", 32'(cyc), 32'(2 + 2 * LEN));
        repeat (3) tick();

        // Start with the window closed for 100 cycles.
        writable = 1'b0;
        wr_hold  = 100;
        start(8'h41);
        for (int i = 0; i < 100; i++) begin
            check("pend_quiet", 32'({src_read, vram_write_enable, dma_busy}), 32'(3'b001));
            tick();
        end
        cyc = 0;
        while (dma_writes == 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("t2_first_write_lat", 32'(cyc), 32'(3));
        run_until_idle("t2", 2000, cyc);
        check_transfer("t2");
        repeat (2) tick();

        // CPU steals the port for 3 cycles while byte 5 is waiting.
        cpu_at = 5;
        start(8'h5A);
        run_until_idle("t3", 2000, cyc);
        check_transfer("t3");
        check("t3_cpu_writes", 32'(cpu_seen), 32'(3));
        repeat (2) tick();

        // Window closes for 1000 cycles at byte 100.
        drop_at  = 100;
        drop_len = 1000;
        start(8'h9C);
        run_until_idle("t4", 4000, cyc);
        check_transfer("t4");
        check("t4_stall_cycles", 32'(cyc >= 1000 + 2 * LEN), 32'(1));
        repeat (2) tick();

        // Reset at byte 40, then a fresh transfer from page 0x03.
        start(8'h11);
        cyc = 0;
        while (exp_n < 40 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("t5_reach_40", 32'(exp_n), 32'(40));
        rst        = 1'b0;
        dma_start  = 1'b0;
        src_valid  = 1'b0;
        model_busy = 1'b0;
        wait_cnt   = 0;
        #1;
        check("t5_rst_src_read", 32'(src_read), 32'(0));
        check("t5_rst_src_addr", 32'(src_address), 32'(0));
        check("t5_rst_busy", 32'(dma_busy), 32'(0));
        check("t5_rst_vram_we", 32'(vram_write_enable), 32'(0));
        repeat (3) tick();
        check("t5_abort_no_done", 32'(done_cnt), 32'(0));
        rst = 1'b1;
        repeat (3) tick();
        check("t5_abort_no_late_done", 32'(done_cnt), 32'(0));
        start(8'h03);
        run_until_idle("t5", 2000, cyc);
        check_transfer("t5");
        repeat (2) tick();

        // Starts while busy and during DONE, plus unsolicited src_valid.
        set_mode(1, 0, 0, 1'b1);
        restart_at   = 50;
        done_restart = 1'b1;
        start(8'hC4);
        run_until_idle("t6", 3000, cyc);
        check_transfer("t6");
        done_restart = 1'b0;
        repeat (5) tick();
        check("t6_no_requeue_done", 32'(done_cnt), 32'(1));

        // Randomized window, CPU traffic and source latency.
        set_mode(3, 30, 15, 1'b1);
        for (int t = 0; t < 3; t++) begin
            start(8'($urandom_range(255, 0)));
            run_until_idle("rnd", 12000, cyc);
            check_transfer("rnd");
            repeat (4) tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/obm_dma.md
Name: obm_dma

Overview:
- Sequences bulk copies of object attribute data from CPU-side RAM into Object Memory (VRAM 0x800–0x8FF).
- Shares the single VRAM write port between direct CPU writes and the DMA engine.
- Sits between the CPU bus decode and foreground_m's data_in/address/write_enable port.
- Writes are issued only while the video timing asserts writable.

Parameters:
- LENGTH, 256, number of bytes per transfer (1..256).
- DEST_BASE, 12'h800, first VRAM destination address.

Ports:
- clk  in  1  GPU pixel clock (12.5875 MHz).
- rst  in  1  asynchronous, active-low reset.
- writable  in  1  VRAM write window from video timing.
- cpu_data  in  8  CPU write data.
- cpu_address  in  `VRAM_ADDR_WIDTH  CPU VRAM address.
- cpu_write_enable  in  1  CPU VRAM write strobe.
- dma_start  in  1  single-cycle transfer request.
- dma_page  in  8  source page; source address = {dma_page, index}.
- src_address  out  16  source RAM read address.
- src_read  out  1  source read request, held until acknowledged.
- src_data  in  8  source read data.
- src_valid  in  1  source acknowledge; src_data valid this cycle.
- vram_data  out  8  to foreground data_in.
- vram_address  out  `VRAM_ADDR_WIDTH  to foreground address.
- vram_write_enable  out  1  to foreground write_enable.
- dma_busy  out  1  transfer pending or active.
- dma_done  out  1  single-cycle pulse when the last byte is written.

Behaviour:
- Reset (rst low, async):
  - State IDLE; index=0; page=0; byte buffer=0.
  - src_read=0, src_address=0, dma_busy=0, dma_done=0, vram_write_enable=0.
- States and transitions:
  - IDLE → PEND on dma_start; latch dma_page; index=0.
  - PEND → READ on the first cycle writable=1.
  - READ: src_read=1, src_address={page,index}. On src_valid, capture src_data → WRITE. Address is stable while src_read=1.
  - WRITE: if writable=1 and cpu_write_enable=0, drive the DMA write this cycle.
    - If index==LENGTH-1 → DONE; else index+1 → READ.
    - Otherwise stall in WRITE, holding the buffer.
  - DONE: dma_done=1 for exactly one cycle → IDLE.
- dma_busy=1 in PEND, READ, WRITE and DONE.
- VRAM mux (combinational, zero latency):
  - If cpu_write_enable=1, pass cpu_data/cpu_address through.
  - Else if state==WRITE and writable=1, drive {buffer, DEST_BASE+index} with vram_write_enable=1.
  - Else vram_write_enable=0.
  - The CPU always wins; a DMA byte is never dropped, only delayed.
- The CPU write path is not gated by writable here; foreground_m gates it.
- writable falling mid-transfer:
  - READ may still complete its handshake.
  - WRITE stalls until writable=1.
  - Transfers spanning frames are legal.
- dma_start while dma_busy=1 is ignored; no queueing.
- dma_start in the same cycle as DONE is ignored.
- index is 8 bits; DEST_BASE+index never exceeds DEST_BASE+LENGTH-1 and is computed at `VRAM_ADDR_WIDTH bits.
- src_valid while src_read=0 is ignored.
- Throughput: minimum 2 cycles/byte when src_valid returns the cycle after the request, so 256 bytes take ≥512 cycles of writable.
- Reset mid-transfer aborts immediately, with no dma_done. Already-written OBM bytes remain.

Decomposition:
- Shared package gpu_pkg:
  - state enum typedef dma_state_t {IDLE, PEND, READ, WRITE, DONE}.
  - OBM_BASE=12'h800.
  - OBM_SIZE=256.
  - `VRAM_ADDR_WIDTH remains from parameters.vh.
- One natural sub-module, vram_write_mux: the combinational CPU/DMA priority mux.

Test Plan:
- writable=1, src_valid one cycle after src_read, dma_start with dma_page=8'h02 → src_address 0x0200..0x02FF in order; 256 writes to 0x800..0x8FF with data matching source; dma_done pulses once; dma_busy falls the same edge dma_done falls.
- dma_start with writable=0 for 100 cycles → state stays PEND, src_read=0, no vram writes; first write follows writable rising.
- During WRITE of index 5, assert cpu_write_enable to 0x010 with data 0xAA for 3 cycles → vram shows 0x010/0xAA for 3 cycles; then DMA writes 0x805 exactly once.
- writable drops at index 100 for 1000 cycles → writes stop, buffer is held; on resume 0x864 is written with the correct byte; total DMA writes = 256.
- rst low at index 40, then a new dma_start with page 8'h03 → outputs zero during reset; no dma_done for the aborted transfer; the new transfer starts from 0x0300/0x800.
- Second dma_start while busy, and src_valid asserted with no request → no effect on sequence, count or dma_done.
